// File: rtl/sha3_io_pkg.sv
// Shared constants, types and chunk-slice helper for the SHA-3 chunked I/O blocks
// (input assembler and output serializer).
package sha3_io_pkg;

    localparam int unsigned CHUNK_W = 200;
    localparam int unsigned NCHUNK  = 8;
    localparam int unsigned IX_W    = 3;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned STATE_W = CHUNK_W * NCHUNK;
    // Chunk NCHUNK-1 goes straight to the holding register, so assembly keeps only the rest.
    localparam int unsigned ASM_W   = STATE_W - CHUNK_W;

    typedef logic [IX_W-1:0] chunk_ix_t;

    localparam chunk_ix_t LAST_IX = chunk_ix_t'(NCHUNK - 1);

    typedef enum logic [1:0] {
        DecIdle,
        DecAccept,
        DecRestart,
        DecDrop
    } chunk_dec_e;

    function automatic int unsigned chunk_lsb(chunk_ix_t ix);
        return CHUNK_W * 32'(ix);
    endfunction

endpackage

// File: rtl/sha3_input_assembler_if.sv
// Chunked-state bus between the upstream producer, the input assembler and the core.
interface sha3_input_assembler_if;
    import sha3_io_pkg::*;

    logic                 pushin;
    chunk_ix_t            dinix;
    logic [CHUNK_W-1:0]   din;
    logic [TAG_W-1:0]     tagin;
    logic                 stopout;
    logic                 pushout;
    logic                 stopin;
    logic [STATE_W-1:0]   dout;
    logic [TAG_W-1:0]     tagout;
    logic                 err;

    modport slave (
        input  pushin, dinix, din, tagin, stopin,
        output stopout, pushout, dout, tagout, err
    );

    modport master (
        output pushin, dinix, din, tagin, stopin,
        input  stopout, pushout, dout, tagout, err
    );

endinterface

// File: rtl/sha3_chunk_tracker.sv
// Tracks the expected chunk index and classifies each pushed chunk as accept, restart or drop;
// drops raise a registered one-cycle err pulse.
module sha3_chunk_tracker
    import sha3_io_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pushin_i,
    input  chunk_ix_t  dinix_i,
    input  logic       hold_v_i,
    output chunk_dec_e dec_o,
    output logic       stopout_o,
    output logic       err_o
);

    chunk_ix_t expix_d, expix_q;
    logic      err_d, err_q;

    // The final chunk cannot be taken while the previous state is still held.
    assign stopout_o = hold_v_i && (expix_q == LAST_IX);

    always_comb begin
        dec_o   = DecIdle;
        expix_d = expix_q;
        err_d   = 1'b0;
        if (pushin_i) begin
            if (dinix_i == expix_q && !(dinix_i == LAST_IX && stopout_o)) begin
                dec_o   = DecAccept;
                expix_d = (dinix_i == LAST_IX) ? '0 : expix_q + 1'b1;
            end else if (dinix_i == '0 && expix_q != '0) begin
                dec_o   = DecRestart;
                expix_d = chunk_ix_t'(1);
            end else begin
                dec_o   = DecDrop;
                expix_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            expix_q <= '0;
            err_q   <= 1'b0;
        end else begin
            expix_q <= expix_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/sha3_input_assembler.sv
// Assembles eight indexed 200-bit chunks into a 1600-bit Keccak state and presents it,
// with its tag, to the permutation core through a registered valid/stop handshake.
module sha3_input_assembler
    import sha3_io_pkg::*;
(
    input logic                   clk,
    input logic                   reset,
    sha3_input_assembler_if.slave io
);

    chunk_dec_e           dec;
    logic                 stopout;
    logic                 err;

    logic [ASM_W-1:0]     asm_d, asm_q;
    logic [TAG_W-1:0]     asm_tag_d, asm_tag_q;
    logic [STATE_W-1:0]   hold_d, hold_q;
    logic [TAG_W-1:0]     hold_tag_d, hold_tag_q;
    logic                 hold_v_d, hold_v_q;

    sha3_chunk_tracker u_tracker (
        .clk_i     (clk),
        .reset_i   (reset),
        .pushin_i  (io.pushin),
        .dinix_i   (io.dinix),
        .hold_v_i  (hold_v_q),
        .dec_o     (dec),
        .stopout_o (stopout),
        .err_o     (err)
    );

    always_comb begin
        asm_d      = asm_q;
        asm_tag_d  = asm_tag_q;
        hold_d     = hold_q;
        hold_tag_d = hold_tag_q;
        hold_v_d   = hold_v_q;
        if (hold_v_q && !io.stopin) begin
            hold_v_d = 1'b0;
        end
        if (dec == DecAccept || dec == DecRestart) begin
            if (io.dinix == LAST_IX) begin
                // Completion overrides a same-edge drain so the new state stays valid.
                hold_d     = {io.din, asm_q};
                hold_tag_d = asm_tag_q;
                hold_v_d   = 1'b1;
            end else begin
                asm_d[chunk_lsb(io.dinix) +: CHUNK_W] = io.din;
            end
            if (io.dinix == '0) begin
                asm_tag_d = io.tagin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q      <= '0;
            asm_tag_q  <= '0;
            hold_q     <= '0;
            hold_tag_q <= '0;
            hold_v_q   <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            asm_tag_q  <= asm_tag_d;
            hold_q     <= hold_d;
            hold_tag_q <= hold_tag_d;
            hold_v_q   <= hold_v_d;
        end
    end

    assign io.pushout = hold_v_q;
    assign io.dout    = hold_q;
    assign io.tagout  = hold_tag_q;
    assign io.stopout = stopout;
    assign io.err     = err;

endmodule

// File: tb/tb_sha3_input_assembler.sv
// Directed bench for sha3_input_assembler: a vector table for in-order, error and restart
// flows, plus hand-written sequences for back-pressure, late chunk 7 and reset.
module tb_sha3_input_assembler;

    logic clk = 1'b0;
    logic reset = 1'b1;

    sha3_input_assembler_if bus ();

    sha3_input_assembler dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pi;
        int          ix;
        logic [7:0]  db;
        logic [7:0]  tag;
        logic        si;
        logic        po;
        logic        so;
        logic        er;
        logic [7:0]  etag;
        logic [63:0] edout;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Byte b+k in lane k: shorthand for a state whose chunk k is that byte replicated.
    function automatic logic [63:0] seq8(input logic [7:0] b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = b + 8'(k);
        return r;
    endfunction

    function automatic logic [1599:0] expand(input logic [63:0] b);
        logic [1599:0] r;
        for (int k = 0; k < 8; k++) r[200*k +: 200] = {25{b[8*k +: 8]}};
        return r;
    endfunction

    task automatic add(input logic rst, pi, input int ix, input logic [7:0] db, tag,
                       input logic si, po, so, er, input logic [7:0] etag,
                       input logic [63:0] ed);
        vec_t v;
        v.rst = rst; v.pi = pi; v.ix = ix; v.db = db; v.tag = tag; v.si = si;
        v.po = po; v.so = so; v.er = er; v.etag = etag; v.edout = ed;
        tbl.push_back(v);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s got %b want %b", n_vec, nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, pi, input int ix, input logic [7:0] db, tag,
                        input logic si, po, so, er, input logic [7:0] etag,
                        input logic [63:0] ed);
        logic [1599:0] want;
        logic          bad;
        reset      = rst;
        bus.pushin = pi;
        bus.dinix  = 3'(ix);
        bus.din    = {25{db}};
        bus.tagin  = tag;
        bus.stopin = si;
        @(posedge clk);
        #1;
        n_vec++;
        chk1("pushout", bus.pushout, po);
        chk1("stopout", bus.stopout, so);
        chk1("err", bus.err, er);
        n_cmp++;
        if (bus.tagout !== etag) begin
            n_fail++;
            $display("FAIL v%0d tagout got %h want %h", n_vec, bus.tagout, etag);
        end
        want = expand(ed);
        n_cmp++;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!bad && bus.dout[200*k +: 200] !== want[200*k +: 200]) begin
                bad = 1'b1;
                n_fail++;
                $display("FAIL v%0d dout chunk %0d got %h want %h", n_vec, k,
                         bus.dout[200*k +: 200], want[200*k +: 200]);
            end
        end
    endtask

    initial begin
        bus.pushin = 1'b0;
        bus.dinix  = '0;
        bus.din    = '0;
        bus.tagin  = '0;
        bus.stopin = 1'b0;

        // Reset state.
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 64'h0);
        // In-order state, no back-pressure.
        for (int k = 0; k < 7; k++)
            add(0, 1, k, 8'(k), 8'hA5, 0, 0, 0, 0, 8'h00, 64'h0);
        add(0, 1, 7, 8'h07, 8'hA5, 0, 1, 0, 0, 8'hA5, seq8(8'h00));
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, seq8(8'h00));
        // Skipped index 2: drop with err, then a clean state.
        add(0, 1, 0, 8'h10, 8'h11, 0, 0, 0, 0, 8'hA5, seq8(8'h00));
        add(0, 1, 1, 8'h11, 8'h11, 0, 0, 0, 0, 8'hA5, seq8(8'h00));
        add(0, 1, 3, 8'h13, 8'h11, 0, 0, 0, 1, 8'hA5, seq8(8'h00));
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, seq8(8'h00));
        for (int k = 0; k < 7; k++)
            add(0, 1, k, 8'h20 + 8'(k), 8'h22, 0, 0, 0, 0, 8'hA5, seq8(8'h00));
        add(0, 1, 7, 8'h27, 8'h22, 0, 1, 0, 0, 8'h22, seq8(8'h20));
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h22, seq8(8'h20));
        // Restart at index 0 mid-state: new tag and chunk-0 data, no err.
        for (int k = 0; k < 5; k++)
            add(0, 1, k, 8'h30 + 8'(k), 8'h33, 0, 0, 0, 0, 8'h22, seq8(8'h20));
        add(0, 1, 0, 8'h40, 8'h3C, 0, 0, 0, 0, 8'h22, seq8(8'h20));
        for (int k = 1; k < 7; k++)
            add(0, 1, k, 8'h40 + 8'(k), 8'hFF, 0, 0, 0, 0, 8'h22, seq8(8'h20));
        add(0, 1, 7, 8'h47, 8'hFF, 0, 1, 0, 0, 8'h3C, seq8(8'h40));
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h3C, seq8(8'h40));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].pi, tbl[i].ix, tbl[i].db, tbl[i].tag, tbl[i].si,
                 tbl[i].po, tbl[i].so, tbl[i].er, tbl[i].etag, tbl[i].edout);
        end

        // Back-pressure: A held while B0..B6 fill, stopout after B6, then B7 after drain.
        for (int k = 0; k < 7; k++)
            step(0, 1, k, 8'h50 + 8'(k), 8'h5A, 1, 0, 0, 0, 8'h3C, seq8(8'h40));
        step(0, 1, 7, 8'h57, 8'h5A, 1, 1, 0, 0, 8'h5A, seq8(8'h50));
        for (int k = 0; k < 6; k++)
            step(0, 1, k, 8'h60 + 8'(k), 8'h6B, 1, 1, 0, 0, 8'h5A, seq8(8'h50));
        step(0, 1, 6, 8'h66, 8'h6B, 1, 1, 1, 0, 8'h5A, seq8(8'h50));
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h5A, seq8(8'h50));
        step(0, 1, 7, 8'h67, 8'h00, 0, 1, 0, 0, 8'h6B, seq8(8'h60));
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h6B, seq8(8'h60));

        // Chunk 7 pushed while stopout=1: dropped, err, hold C intact, D lost.
        for (int k = 0; k < 7; k++)
            step(0, 1, k, 8'h70 + 8'(k), 8'h7C, 1, 0, 0, 0, 8'h6B, seq8(8'h60));
        step(0, 1, 7, 8'h77, 8'h7C, 1, 1, 0, 0, 8'h7C, seq8(8'h70));
        for (int k = 0; k < 6; k++)
            step(0, 1, k, 8'h80 + 8'(k), 8'h8D, 1, 1, 0, 0, 8'h7C, seq8(8'h70));
        step(0, 1, 6, 8'h86, 8'h8D, 1, 1, 1, 0, 8'h7C, seq8(8'h70));
        step(0, 1, 7, 8'h87, 8'h8D, 1, 1, 0, 1, 8'h7C, seq8(8'h70));
        step(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h7C, seq8(8'h70));
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h7C, seq8(8'h70));
        for (int k = 0; k < 7; k++)
            step(0, 1, k, 8'h90 + 8'(k), 8'h9E, 0, 0, 0, 0, 8'h7C, seq8(8'h70));
        step(0, 1, 7, 8'h97, 8'h9E, 0, 1, 0, 0, 8'h9E, seq8(8'h90));
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h9E, seq8(8'h90));

        // Reset during chunk 4 and during a held pushout; first post-reset push is ix 2.
        for (int k = 0; k < 4; k++)
            step(0, 1, k, 8'hA0 + 8'(k), 8'hAA, 0, 0, 0, 0, 8'h9E, seq8(8'h90));
        step(1, 1, 4, 8'hA4, 8'hAA, 0, 0, 0, 0, 8'h00, 64'h0);
        for (int k = 0; k < 7; k++)
            step(0, 1, k, 8'hB0 + 8'(k), 8'hBB, 1, 0, 0, 0, 8'h00, 64'h0);
        step(0, 1, 7, 8'hB7, 8'hBB, 1, 1, 0, 0, 8'hBB, seq8(8'hB0));
        step(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'hBB, seq8(8'hB0));
        step(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 64'h0);
        step(0, 1, 2, 8'hC2, 8'hCC, 0, 0, 0, 1, 8'h00, 64'h0);
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 64'h0);
        for (int k = 0; k < 7; k++)
            step(0, 1, k, 8'hC0 + 8'(k), 8'hCC, 0, 0, 0, 0, 8'h00, 64'h0);
        step(0, 1, 7, 8'hC7, 8'hCC, 0, 1, 0, 0, 8'hCC, seq8(8'hC0));
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hCC, seq8(8'hC0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
